// File: rtl/gemm_result_serializer.sv
// Captures a SIZE x SIZE result matrix after a programmable settle delay and
// streams it row-major, one element per accepted valid/ready beat.
module gemm_result_serializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int SIZE        = 4,
   parameter int WAIT_CYCLES = 0,
   parameter int IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start_in,
   input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]   mat_in,
   output logic                                        busy_out,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       out_data,
   output logic [IDX_W-1:0]                            out_row,
   output logic [IDX_W-1:0]                            out_col,
   output logic                                        out_last,
   output logic                                        done_out
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_STREAM
   } state_t;

   state_t                                    r_state;
   state_t                                    w_next;
   logic [CNT_W-1:0]                          r_cnt;
   logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] r_buf;
   logic [IDX_W-1:0]                          r_row;
   logic [IDX_W-1:0]                          r_col;
   logic                                      r_done;
   logic                                      w_capture;
   logic                                      w_load;
   logic                                      w_xfer;
   logic                                      w_last;

   assign w_last = (r_state == ST_STREAM) && (r_row == IDX_MAX) && (r_col == IDX_MAX);

   // Capture happens on the edge that leaves IDLE (no delay) or the edge where the wait counter hits zero.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_load    = 1'b0;
      w_xfer    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_in) begin
               if (WAIT_CYCLES == 0) begin
                  w_capture = 1'b1;
                  w_next    = ST_STREAM;
               end else begin
                  w_load = 1'b1;
                  w_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture = 1'b1;
               w_next    = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (out_ready) begin
               w_xfer = 1'b1;
               if (w_last) begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_buf  <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_xfer && w_last;
         if (w_load) begin
            r_cnt <= CNT_LOAD;
         end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_buf <= mat_in;
         end
         // Only an accepted beat moves the read pointer, so stalls hold the element in place.
         if (w_xfer) begin
            if (w_last) begin
               r_row <= '0;
               r_col <= '0;
            end else if (r_col == IDX_MAX) begin
               r_col <= '0;
               r_row <= r_row + IDX_W'(1);
            end else begin
               r_col <= r_col + IDX_W'(1);
            end
         end
      end
   end

   assign busy_out  = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_STREAM);
   assign out_data  = out_valid ? r_buf[r_row][r_col] : '0;
   assign out_row   = r_row;
   assign out_col   = r_col;
   assign out_last  = w_last;
   assign done_out  = r_done;

endmodule
